// File: rtl/jtag_pkg.sv
// Shared JTAG TAP definitions: IEEE 1149.1 state encoding, default opcodes and
// the data-register select type used by the instruction decode.
package jtag_pkg;

  typedef enum logic [3:0] {
    StEx2Dr = 4'h0,
    StEx1Dr = 4'h1,
    StShDr  = 4'h2,
    StPauDr = 4'h3,
    StSelIr = 4'h4,
    StUpdDr = 4'h5,
    StCapDr = 4'h6,
    StSelDr = 4'h7,
    StEx2Ir = 4'h8,
    StEx1Ir = 4'h9,
    StShIr  = 4'hA,
    StPauIr = 4'hB,
    StRti   = 4'hC,
    StUpdIr = 4'hD,
    StCapIr = 4'hE,
    StTlr   = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    DrBypass,
    DrIdcode,
    DrUsercode,
    DrBsr
  } dr_sel_e;

  localparam int unsigned DefIrWidth  = 4;
  localparam int unsigned OpSample    = 1;
  localparam int unsigned OpExtest    = 2;
  localparam int unsigned OpIntest    = 3;
  localparam int unsigned OpIdcode    = 7;
  localparam int unsigned OpUsercode  = 8;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller: TMS-driven state register plus per-state action
// strobes consumed by the IR and data registers in the top.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck_i,
  input  logic       rst_i,
  input  logic       tms_i,
  output tap_state_e state_o,
  output logic       tlr_o,
  output logic       capture_dr_o,
  output logic       shift_dr_o,
  output logic       update_dr_o,
  output logic       capture_ir_o,
  output logic       shift_ir_o,
  output logic       update_ir_o
);

  tap_state_e state_q, state_d;

  always_ff @(posedge tck_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StTlr;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StTlr;
    case (state_q)
      StTlr:   state_d = tms_i ? StTlr   : StRti;
      StRti:   state_d = tms_i ? StSelDr : StRti;
      StSelDr: state_d = tms_i ? StSelIr : StCapDr;
      StCapDr: state_d = tms_i ? StEx1Dr : StShDr;
      StShDr:  state_d = tms_i ? StEx1Dr : StShDr;
      StEx1Dr: state_d = tms_i ? StUpdDr : StPauDr;
      StPauDr: state_d = tms_i ? StEx2Dr : StPauDr;
      StEx2Dr: state_d = tms_i ? StUpdDr : StShDr;
      StUpdDr: state_d = tms_i ? StSelDr : StRti;
      StSelIr: state_d = tms_i ? StTlr   : StCapIr;
      StCapIr: state_d = tms_i ? StEx1Ir : StShIr;
      StShIr:  state_d = tms_i ? StEx1Ir : StShIr;
      StEx1Ir: state_d = tms_i ? StUpdIr : StPauIr;
      StPauIr: state_d = tms_i ? StEx2Ir : StPauIr;
      StEx2Ir: state_d = tms_i ? StUpdIr : StShIr;
      StUpdIr: state_d = tms_i ? StSelDr : StRti;
      default: state_d = StTlr;
    endcase
  end

  // Strobes reflect the current state: the action happens on the edge leaving it.
  always_comb begin
    tlr_o        = (state_q == StTlr);
    capture_dr_o = (state_q == StCapDr);
    shift_dr_o   = (state_q == StShDr);
    update_dr_o  = (state_q == StUpdDr);
    capture_ir_o = (state_q == StCapIr);
    shift_ir_o   = (state_q == StShIr);
    update_ir_o  = (state_q == StUpdIr);
  end

  assign state_o = state_q;

endmodule

// File: rtl/jtag_tap_param.sv
// Parametrised JTAG TAP: IR, instruction decode, BYPASS/IDCODE/USERCODE/BSR data
// registers, registered TDO and the functional/test muxes between pins and core.
module jtag_tap_param
  import jtag_pkg::*;
#(
  parameter int unsigned         IR_WIDTH     = DefIrWidth,
  parameter int unsigned         N_IO         = 4,
  parameter logic [31:0]         IDCODE_VAL   = 32'h1234_5001,
  parameter logic [31:0]         USERCODE_VAL = 32'h0000_00A5,
  parameter logic [IR_WIDTH-1:0] OP_SAMPLE    = IR_WIDTH'(OpSample),
  parameter logic [IR_WIDTH-1:0] OP_EXTEST    = IR_WIDTH'(OpExtest),
  parameter logic [IR_WIDTH-1:0] OP_INTEST    = IR_WIDTH'(OpIntest),
  parameter logic [IR_WIDTH-1:0] OP_IDCODE    = IR_WIDTH'(OpIdcode),
  parameter logic [IR_WIDTH-1:0] OP_USERCODE  = IR_WIDTH'(OpUsercode)
) (
  input  logic                TCK,
  input  logic                RESET,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                TDO_EN,
  output logic [3:0]          STATE,
  output logic [IR_WIDTH-1:0] IR_OUT,
  input  logic [N_IO-1:0]     PIN_IN,
  output logic [N_IO-1:0]     PIN_OUT,
  input  logic [N_IO-1:0]     CORE_OUT,
  output logic [N_IO-1:0]     CORE_IN
);

  localparam int unsigned BsrLen = 2 * N_IO;

  tap_state_e state;
  logic tlr, capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir;

  jtag_tap_fsm u_fsm (
    .tck_i        (TCK),
    .rst_i        (RESET),
    .tms_i        (TMS),
    .state_o      (state),
    .tlr_o        (tlr),
    .capture_dr_o (capture_dr),
    .shift_dr_o   (shift_dr),
    .update_dr_o  (update_dr),
    .capture_ir_o (capture_ir),
    .shift_ir_o   (shift_ir),
    .update_ir_o  (update_ir)
  );

  logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic                byp_q, byp_d;
  logic [31:0]         id_sr_q, id_sr_d;
  logic [BsrLen-1:0]   bsr_q, bsr_d;
  logic [N_IO-1:0]     pin_upd_q, pin_upd_d;
  logic [N_IO-1:0]     core_upd_q, core_upd_d;
  logic                tdo_q, tdo_d;
  logic                tdo_en_q, tdo_en_d;
  dr_sel_e             dr_sel;

  // Anything not explicitly recognised, including all ones, falls back to BYPASS.
  always_comb begin
    dr_sel = DrBypass;
    if (ir_q == OP_IDCODE) begin
      dr_sel = DrIdcode;
    end else if (ir_q == OP_USERCODE) begin
      dr_sel = DrUsercode;
    end else if (ir_q == OP_SAMPLE || ir_q == OP_EXTEST || ir_q == OP_INTEST) begin
      dr_sel = DrBsr;
    end
  end

  always_comb begin
    ir_sr_d    = ir_sr_q;
    ir_d       = ir_q;
    byp_d      = byp_q;
    id_sr_d    = id_sr_q;
    bsr_d      = bsr_q;
    pin_upd_d  = pin_upd_q;
    core_upd_d = core_upd_q;
    tdo_d      = tdo_q;
    tdo_en_d   = shift_dr | shift_ir;

    if (tlr) begin
      ir_d = OP_IDCODE;
    end

    if (capture_ir) begin
      ir_sr_d      = '0;
      ir_sr_d[1:0] = 2'b01;
    end
    if (shift_ir) begin
      tdo_d   = ir_sr_q[0];
      ir_sr_d = {TDI, ir_sr_q[IR_WIDTH-1:1]};
    end
    if (update_ir) begin
      ir_d = ir_sr_q;
    end

    if (capture_dr) begin
      unique case (dr_sel)
        DrBypass:   byp_d   = 1'b0;
        DrIdcode:   id_sr_d = IDCODE_VAL;
        DrUsercode: id_sr_d = USERCODE_VAL;
        DrBsr:      bsr_d   = {PIN_IN, CORE_OUT};
      endcase
    end

    if (shift_dr) begin
      unique case (dr_sel)
        DrBypass: begin
          tdo_d = byp_q;
          byp_d = TDI;
        end
        DrIdcode, DrUsercode: begin
          tdo_d   = id_sr_q[0];
          id_sr_d = {TDI, id_sr_q[31:1]};
        end
        DrBsr: begin
          tdo_d = bsr_q[0];
          bsr_d = {TDI, bsr_q[BsrLen-1:1]};
        end
      endcase
    end

    if (update_dr && dr_sel == DrBsr) begin
      pin_upd_d  = bsr_q[BsrLen-1:N_IO];
      core_upd_d = bsr_q[N_IO-1:0];
    end
  end

  always_ff @(posedge TCK or posedge RESET) begin
    if (RESET) begin
      ir_sr_q    <= '0;
      ir_q       <= OP_IDCODE;
      byp_q      <= 1'b0;
      id_sr_q    <= '0;
      bsr_q      <= '0;
      pin_upd_q  <= '0;
      core_upd_q <= '0;
      tdo_q      <= 1'b0;
      tdo_en_q   <= 1'b0;
    end else begin
      ir_sr_q    <= ir_sr_d;
      ir_q       <= ir_d;
      byp_q      <= byp_d;
      id_sr_q    <= id_sr_d;
      bsr_q      <= bsr_d;
      pin_upd_q  <= pin_upd_d;
      core_upd_q <= core_upd_d;
      tdo_q      <= tdo_d;
      tdo_en_q   <= tdo_en_d;
    end
  end

  // SAMPLE leaves both paths functional; only EXTEST/INTEST take over a direction.
  assign PIN_OUT = (ir_q == OP_EXTEST) ? pin_upd_q  : CORE_OUT;
  assign CORE_IN = (ir_q == OP_INTEST) ? core_upd_q : PIN_IN;

  assign TDO    = tdo_q;
  assign TDO_EN = tdo_en_q;
  assign STATE  = state;
  assign IR_OUT = ir_q;

endmodule

// File: tb/tb_jtag_tap_param.sv
// Self-checking bench for jtag_tap_param: TDO bits go through an expectation
// queue; instruction/data scans come from a vector table plus hand sequences.
module tb_jtag_tap_param;

  localparam int unsigned IrW = 4;
  localparam int unsigned NIo = 4;

  logic           TCK = 1'b0;
  logic           RESET;
  logic           TMS;
  logic           TDI;
  logic           TDO;
  logic           TDO_EN;
  logic [3:0]     STATE;
  logic [IrW-1:0] IR_OUT;
  logic [NIo-1:0] PIN_IN;
  logic [NIo-1:0] PIN_OUT;
  logic [NIo-1:0] CORE_OUT;
  logic [NIo-1:0] CORE_IN;

  int n_cmp = 0;
  int n_err = 0;
  logic exp_q[$];

  typedef struct {
    string          name;
    logic [IrW-1:0] op;
    int             n;
    logic [63:0]    tdi;
    logic [63:0]    exp_tdo;
    logic [NIo-1:0] exp_pin_out;
    logic [NIo-1:0] exp_core_in;
  } vec_t;

  vec_t vecs [6];

  always #5 TCK = ~TCK;

  jtag_tap_param dut (
    .TCK      (TCK),
    .RESET    (RESET),
    .TMS      (TMS),
    .TDI      (TDI),
    .TDO      (TDO),
    .TDO_EN   (TDO_EN),
    .STATE    (STATE),
    .IR_OUT   (IR_OUT),
    .PIN_IN   (PIN_IN),
    .PIN_OUT  (PIN_OUT),
    .CORE_OUT (CORE_OUT),
    .CORE_IN  (CORE_IN)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    #1;
  endtask

  // Assumes the TAP sits in a shift state; last bit leaves via TMS=1 to Exit1.
  task automatic shift(input string name, input int n, input logic [63:0] tdi,
                       input logic [63:0] exp);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(exp[i]);
      tick(i == n - 1, tdi[i]);
      if (i == 0 && n > 1) check({name, "_tdo_en"}, TDO_EN, 1);
      check($sformatf("%s_bit%0d", name, i), TDO, exp_q.pop_front());
    end
  endtask

  task automatic load_ir(input logic [IrW-1:0] op);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    shift("ir_capture", IrW, 64'(op), 64'h1);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("ir_out", IR_OUT, op);
  endtask

  task automatic dr_scan(input string name, input int n, input logic [63:0] tdi,
                         input logic [63:0] exp);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    shift(name, n, tdi, exp);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"usercode", 4'h8, 32, 64'h0F0F_1234, 64'h0000_00A5, 4'h6, 4'h3};
    vecs[1] = '{"bypass",   4'hF, 8,  64'hB6,       64'h6C,        4'h6, 4'h3};
    vecs[2] = '{"undef_c",  4'hC, 8,  64'h5A,       64'hB4,        4'h6, 4'h3};
    vecs[3] = '{"extest",   4'h2, 8,  64'hA0,       64'h36,        4'hA, 4'h3};
    vecs[4] = '{"intest",   4'h3, 8,  64'h05,       64'h36,        4'h6, 4'h5};
    vecs[5] = '{"sample",   4'h1, 8,  64'h9C,       64'h36,        4'h6, 4'h3};

    RESET    = 1'b1;
    TMS      = 1'b1;
    TDI      = 1'b0;
    PIN_IN   = 4'h3;
    CORE_OUT = 4'h6;
    repeat (2) @(posedge TCK);
    #1;
    check("rst_state", STATE, 4'hF);
    check("rst_ir_out", IR_OUT, 4'h7);
    check("rst_tdo", TDO, 0);
    check("rst_tdo_en", TDO_EN, 0);
    check("rst_pin_out", PIN_OUT, 4'h6);
    check("rst_core_in", CORE_IN, 4'h3);
    RESET = 1'b0;

    // IDCODE is the default instruction: 32 capture bits, then TDI 32 edges later.
    tick(1'b0, 1'b0);
    check("rti_state", STATE, 4'hC);
    dr_scan("idcode", 64, {32'h0, 32'hCAFE_F00D}, {32'hCAFE_F00D, 32'h1234_5001});

    foreach (vecs[k]) begin
      load_ir(vecs[k].op);
      dr_scan(vecs[k].name, vecs[k].n, vecs[k].tdi, vecs[k].exp_tdo);
      check({vecs[k].name, "_pin_out"}, PIN_OUT, vecs[k].exp_pin_out);
      check({vecs[k].name, "_core_in"}, CORE_IN, vecs[k].exp_core_in);
    end

    // SAMPLE left pin_upd=9: EXTEST must only drive it after the UpdIR edge.
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    shift("ir_extest", IrW, 64'h2, 64'h1);
    tick(1'b1, 1'b0);
    check("updir_state", STATE, 4'hD);
    check("updir_pin_out_old", PIN_OUT, 4'h6);
    tick(1'b0, 1'b0);
    check("extest_pin_out_new", PIN_OUT, 4'h9);
    check("extest_core_in", CORE_IN, 4'h3);
    CORE_OUT = 4'hF;
    PIN_IN   = 4'hB;
    #1;
    check("extest_pin_out_hold", PIN_OUT, 4'h9);
    check("extest_core_in_track", CORE_IN, 4'hB);
    CORE_OUT = 4'h6;
    PIN_IN   = 4'h3;

    // Asynchronous reset in the middle of a DR shift.
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    check("mid_shdr_state", STATE, 4'h2);
    RESET = 1'b1;
    #1;
    check("mid_rst_state", STATE, 4'hF);
    check("mid_rst_ir_out", IR_OUT, 4'h7);
    check("mid_rst_tdo", TDO, 0);
    check("mid_rst_tdo_en", TDO_EN, 0);
    check("mid_rst_pin_out", PIN_OUT, 4'h6);
    tick(1'b0, 1'b0);
    RESET = 1'b0;
    tick(1'b0, 1'b0);
    check("post_rst_rti", STATE, 4'hC);
    repeat (5) tick(1'b1, 1'b0);
    check("tms5_from_rti", STATE, 4'hF);

    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("shdr_again", STATE, 4'h2);
    repeat (5) tick(1'b1, 1'b0);
    check("tms5_from_shdr", STATE, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
